sipo_frame_ctrl: RTL and testbench

Controller that sequences a serial-in/parallel-out shift register for framed serial input. It detects start-of-frame, counts accepted bits, and moves each completed WIDTH-bit word into an output holding register. The output register drives a valid/ready handshake toward the downstream consumer. It sits between a serial line front end, which supplies bit strobes, and any parallel-word consumer.

---
 rtl/sipo_frame_ctrl.sv | 111 +++++++++++
 tb/tb_sipo_frame_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl.sv
// Framed serial-to-parallel controller: assembles WIDTH-bit words from qualified
// serial bits and hands them to a consumer over a valid/ready holding register.
module sipo_frame_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_nxt;

  // Partial word needs only WIDTH-1 bits: the final bit goes straight into out_data.
  logic [WIDTH-2:0] sreg, sreg_nxt, base, kept;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_nxt;
  logic             done, load, drop, vld_nxt, ovf_nxt;

  // A start-of-frame bit always begins from an empty register.
  assign base = sof ? '0 : sreg;

  if (MSB_FIRST) begin : g_msb
    assign shifted = {base, sin};
    assign kept    = shifted[WIDTH-2:0];
  end else begin : g_lsb
    assign shifted = {sin, base};
    assign kept    = shifted[WIDTH-1:1];
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = bit_cnt;
    done      = 1'b0;
    if (sin_vld) begin
      case (state)
        IDLE: begin
          if (sof) begin
            state_nxt = SHIFT;
            sreg_nxt  = kept;
            cnt_nxt   = CW'(1);
          end
        end
        SHIFT: begin
          sreg_nxt = kept;
          if (sof) begin
            cnt_nxt = CW'(1);
          end else if (bit_cnt == CW'(WIDTH - 1)) begin
            done      = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = bit_cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Holding register: a finished word is taken if the slot is free or draining now.
  always_comb begin
    load    = done & (~out_vld | out_rdy);
    drop    = done & out_vld & ~out_rdy;
    vld_nxt = out_vld;
    if (load)
      vld_nxt = 1'b1;
    else if (out_vld & out_rdy)
      vld_nxt = 1'b0;
    ovf_nxt = ovf;
    if (drop)
      ovf_nxt = 1'b1;
    else if (ovf_clr)
      ovf_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      out_data <= '0;
      out_vld  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      bit_cnt  <= cnt_nxt;
      out_vld  <= vld_nxt;
      ovf      <= ovf_nxt;
      if (load)
        out_data <= shifted;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl: both bit orders run side by side against
// a bit-list reference model, with directed scenarios followed by random traffic.
module tb_sipo_frame_ctrl;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst = 1'b0, sin = 1'b0, sin_vld = 1'b0, sof = 1'b0, out_rdy = 1'b0, ovf_clr = 1'b0;
  logic [W-1:0]  dm, dl;
  logic          vm, vl, bm, bl, om, ol;
  logic [CW-1:0] cm, cl;

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .sof(sof),
    .out_data(dm), .out_vld(vm), .out_rdy(out_rdy), .busy(bm),
    .bit_cnt(cm), .ovf(om), .ovf_clr(ovf_clr));

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .sof(sof),
    .out_data(dl), .out_vld(vl), .out_rdy(out_rdy), .busy(bl),
    .bit_cnt(cl), .ovf(ol), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  int unsigned n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the current frame is a list of received bits; a word is
  // formed from the list once it holds W entries.
  bit           started = 1'b0;
  bit           mbits[$];
  bit           m_held, m_ovf, m_done;
  logic [W-1:0] m_dm, m_dl, m_wm, m_wl;
  logic [W-1:0] exp_m[$], exp_l[$];

  always @(posedge clk) begin
    if (!rst) begin
      mbits.delete(); exp_m.delete(); exp_l.delete();
      m_held = 1'b0; m_ovf = 1'b0; m_dm = '0; m_dl = '0;
      started = 1'b1;
    end else if (started) begin
      m_done = 1'b0;
      if (sin_vld) begin
        if (sof) begin
          mbits.delete();
          mbits.push_back(sin);
        end else if (mbits.size() > 0) begin
          mbits.push_back(sin);
        end
        if (mbits.size() == W) begin
          m_done = 1'b1;
          for (int i = 0; i < W; i++) begin
            m_wm[W-1-i] = mbits[i];
            m_wl[i]     = mbits[i];
          end
          mbits.delete();
        end
      end
      if (m_done && m_held && !out_rdy) begin
        m_ovf = 1'b1;
      end else begin
        if (ovf_clr) m_ovf = 1'b0;
        if (m_done) begin
          m_held = 1'b1; m_dm = m_wm; m_dl = m_wl;
          exp_m.push_back(m_wm); exp_l.push_back(m_wl);
        end else if (out_rdy) begin
          m_held = 1'b0;
        end
      end
    end
  end

  // Monitor: status compared every cycle; a word is popped from the scoreboard
  // whenever the DUT presents it while the consumer is ready.
  always @(negedge clk) begin
    if (started) begin
      chk("out_vld_msb", {31'd0, vm}, {31'd0, m_held});
      chk("out_vld_lsb", {31'd0, vl}, {31'd0, m_held});
      chk("busy", {30'd0, bm, bl}, (mbits.size() > 0) ? 32'd3 : 32'd0);
      chk("bit_cnt_msb", 32'(cm), mbits.size());
      chk("bit_cnt_lsb", 32'(cl), mbits.size());
      chk("ovf", {30'd0, om, ol}, m_ovf ? 32'd3 : 32'd0);
      chk("out_data_msb", 32'(dm), 32'(m_dm));
      chk("out_data_lsb", 32'(dl), 32'(m_dl));
      if (vm && out_rdy) begin
        if (exp_m.size() == 0 || exp_l.size() == 0) begin
          chk("consume_without_word", 32'd1, 32'd0);
        end else begin
          chk("consumed_msb", 32'(dm), 32'(exp_m.pop_front()));
          chk("consumed_lsb", 32'(dl), 32'(exp_l.pop_front()));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    sin_vld = 1'b0; sof = 1'b0; sin = 1'b0; ovf_clr = 1'b0;
  endtask

  // Sends the first n bits of w, MSB first, with gap idle cycles between bits.
  task automatic send_bits(input logic [W-1:0] w, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      sin = w[W-1-i]; sin_vld = 1'b1; sof = (i == 0);
      cyc();
      sin_vld = 1'b0; sof = 1'b0;
      if (i < n - 1) repeat (gap) cyc();
    end
  endtask

  initial begin
    idle_in(); rst = 1'b0; out_rdy = 1'b1;
    repeat (2) cyc();
    chk("rst_data", 32'(dm), 32'd0);
    chk("rst_vld", {31'd0, vm}, 32'd0);
    chk("rst_busy", {31'd0, bm}, 32'd0);
    chk("rst_cnt", 32'(cm), 32'd0);
    chk("rst_ovf", {31'd0, om}, 32'd0);
    rst = 1'b1; cyc();

    // Contiguous frame, both bit orders
    send_bits(8'hB2, 8, 0);
    chk("t1_vld", {31'd0, vm}, 32'd1);
    chk("t1_msb", 32'(dm), 32'hB2);
    chk("t1_lsb", 32'(dl), 32'h4D);
    chk("t1_cnt", 32'(cm), 32'd0);
    idle_in(); cyc();
    chk("t1_vld_drop", {31'd0, vm}, 32'd0);

    // Gapped frame
    send_bits(8'hB2, 8, 3);
    chk("t2_msb", 32'(dm), 32'hB2);
    chk("t2_busy_after", {31'd0, bm}, 32'd0);
    idle_in(); cyc();

    // Backpressure overflow, then release with clear
    out_rdy = 1'b0;
    send_bits(8'hB2, 8, 0); idle_in(); cyc();
    send_bits(8'h0F, 8, 0);
    chk("t3_ovf", {31'd0, om}, 32'd1);
    chk("t3_keep", 32'(dm), 32'hB2);
    chk("t3_vld", {31'd0, vm}, 32'd1);
    idle_in(); out_rdy = 1'b1; ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("t3_vld_clr", {31'd0, vm}, 32'd0);
    chk("t3_ovf_clr", {31'd0, om}, 32'd0);

    // Mid-frame restart
    send_bits(8'hF0, 4, 0);
    chk("t4_cnt_partial", 32'(cm), 32'd4);
    send_bits(8'hA5, 8, 0);
    chk("t4_msb", 32'(dm), 32'hA5);
    chk("t4_ovf", {31'd0, om}, 32'd0);
    idle_in(); cyc();

    // Reset mid-frame
    send_bits(8'h6B, 5, 0);
    idle_in(); rst = 1'b0; cyc();
    chk("t5_data", 32'(dm), 32'd0);
    chk("t5_status", {28'd0, vm, bm, om, vl}, 32'd0);
    chk("t5_cnt", 32'(cm), 32'd0);
    rst = 1'b1; cyc();
    send_bits(8'h3C, 8, 0);
    chk("t5_msb", 32'(dm), 32'h3C);
    chk("t5_lsb", 32'(dl), 32'h3C);
    idle_in(); cyc();

    // Back-to-back: consumer ready exactly on the second completion edge
    out_rdy = 1'b0;
    send_bits(8'h5A, 8, 0); idle_in(); cyc();
    send_bits(8'hC3, 7, 0);
    sin = 1'b1; sin_vld = 1'b1; sof = 1'b0; out_rdy = 1'b1;
    cyc();
    idle_in(); out_rdy = 1'b0;
    chk("t6_vld", {31'd0, vm}, 32'd1);
    chk("t6_msb", 32'(dm), 32'hC3);
    chk("t6_ovf", {31'd0, om}, 32'd0);
    out_rdy = 1'b1; cyc();
    chk("t6_vld_drop", {31'd0, vm}, 32'd0);

    // Random traffic with backpressure phases and occasional resets
    for (int i = 0; i < 4000; i++) begin
      sin_vld = ($urandom % 10) < 7;
      sin     = 1'($urandom);
      sof     = sin_vld && (($urandom % 12) == 0);
      ovf_clr = ($urandom % 20) == 0;
      rst     = ($urandom % 600) != 0;
      if (((i / 200) % 2) == 0) out_rdy = ($urandom % 4) != 0;
      else                      out_rdy = ($urandom % 4) == 0;
      cyc();
    end

    idle_in(); rst = 1'b1; out_rdy = 1'b1;
    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
